// File: rtl/sprite_anim_seq.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim_seq
// Purpose  : Steps sprite animations, fetches the 8x8 frame word from the
//            sprite ROM and streams it row by row over valid/ready.
// Options  : SPRITE_MIRROR_EN adds a 'mirror' input that bit-reverses rows.
// Revision : 1.0
// ============================================================================
module sprite_anim_seq #(
  parameter int FRAME_TICKS = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  anim_sel,
`ifdef SPRITE_MIRROR_EN
  input  logic        mirror,
`endif
  output logic [3:0]  rom_addr,
  input  logic [63:0] rom_data,
  output logic [7:0]  row_data,
  output logic [2:0]  row_idx,
  output logic        row_valid,
  input  logic        row_ready,
  output logic        frame_done
);

  localparam logic [1:0]       c_load      = 2'd0;
  localparam logic [1:0]       c_capture   = 2'd1;
  localparam logic [1:0]       c_send      = 2'd2;
  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] c_tick_one  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_tick;
  logic             w_wrap;
  logic             r_adv_pend;
  logic             r_phase;
  logic             w_phase_nxt;
  logic [1:0]       r_sel;
  logic             r_mirror;
  logic             w_mirror_in;
  logic [63:0]      r_frame;
  logic [3:0]       r_rom_addr;
  logic [3:0]       w_addr_nxt;
  logic [7:0]       r_row_data;
  logic [2:0]       r_row_idx;
  logic             r_row_valid;
  logic             r_frame_done;
  logic             w_xfer;
  logic             w_last_row;

`ifdef SPRITE_MIRROR_EN
  assign w_mirror_in = mirror;
`else
  assign w_mirror_in = 1'b0;
`endif

  // Row r lives at bits [8*(7-r) +: 8]; 8*(7-r) is simply {~r, 3'b000}.
  function automatic logic [7:0] row_of(input logic [63:0] f, input logic [2:0] idx,
                                        input logic mir);
    logic [7:0] r;
    logic [7:0] o;
    r = f[{~idx, 3'b000} +: 8];
    for (int i = 0; i < 8; i++) o[i] = r[7-i];
    return mir ? o : r;
  endfunction

  assign w_wrap     = (r_tick == c_tick_last);
  assign w_xfer     = r_row_valid & row_ready;
  assign w_last_row = (r_row_idx == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_load;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_load:    w_state_nxt = c_capture;
      c_capture: w_state_nxt = c_send;
      c_send:    if (w_xfer && w_last_row) w_state_nxt = c_load;
      default:   w_state_nxt = c_load;
    endcase
  end

  // Phase/address for the LOAD about to happen; a new selection restarts at phase 0.
  always_comb begin
    w_phase_nxt = r_phase;
    if (anim_sel != r_sel)  w_phase_nxt = 1'b0;
    else if (r_adv_pend)    w_phase_nxt = anim_sel[1] ? 1'b0 : ~r_phase;
    case (anim_sel)
      2'd0:    w_addr_nxt = {3'b000, w_phase_nxt};
      2'd1:    w_addr_nxt = {3'b001, w_phase_nxt};
      2'd2:    w_addr_nxt = 4'd4;
      default: w_addr_nxt = 4'd15;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick       <= '0;
      r_adv_pend   <= 1'b0;
      r_phase      <= 1'b0;
      r_sel        <= 2'd0;
      r_mirror     <= 1'b0;
      r_frame      <= '0;
      r_rom_addr   <= 4'd0;
      r_row_data   <= 8'd0;
      r_row_idx    <= 3'd0;
      r_row_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_tick       <= w_wrap ? '0 : r_tick + c_tick_one;
      r_frame_done <= 1'b0;
      // A wrap coinciding with LOAD is kept for the following LOAD.
      if (r_state == c_load) r_adv_pend <= w_wrap;
      else if (w_wrap)       r_adv_pend <= 1'b1;
      case (r_state)
        c_load: begin
          r_sel      <= anim_sel;
          r_mirror   <= w_mirror_in;
          r_phase    <= w_phase_nxt;
          r_rom_addr <= w_addr_nxt;
        end
        c_capture: begin
          r_frame     <= rom_data;
          r_row_idx   <= 3'd0;
          r_row_data  <= row_of(rom_data, 3'd0, r_mirror);
          r_row_valid <= 1'b1;
        end
        c_send: begin
          if (w_xfer) begin
            if (w_last_row) begin
              r_row_valid  <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_row_idx  <= r_row_idx + 3'd1;
              r_row_data <= row_of(r_frame, r_row_idx + 3'd1, r_mirror);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign row_data   = r_row_data;
  assign row_idx    = r_row_idx;
  assign row_valid  = r_row_valid;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_anim_seq
// Purpose  : Scoreboard bench for sprite_anim_seq with a behavioural sprite ROM.
// Revision : 1.0
// ============================================================================
module tb_sprite_anim_seq;

  localparam int FRAME_TICKS = 4;
  localparam int CNT_W       = 3;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        row_ready = 1'b1;
  logic        mirror    = 1'b0;
  logic [1:0]  anim_sel  = 2'd0;
  logic [3:0]  rom_addr;
  logic [63:0] rom_data;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        row_valid;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [2:0] idx;
    logic [7:0] data;
  } row_t;
  row_t sb[$];

  sprite_anim_seq #(.FRAME_TICKS(FRAME_TICKS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .anim_sel   (anim_sel),
`ifdef SPRITE_MIRROR_EN
    .mirror     (mirror),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .row_data   (row_data),
    .row_idx    (row_idx),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_word(input logic [3:0] a);
    case (a)
      4'd0:    return 64'h2854_4438_1014_1810;
      4'd1:    return 64'h0011_2233_4455_6677;
      4'd2:    return 64'h8142_2418_1824_4281;
      4'd3:    return 64'h0102_0408_1020_40AB;
      4'd4:    return 64'h1818_7E7E_1818_1818;
      4'd15:   return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'hDEAD_BEEF_0000_0000 | {60'd0, a};
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[7-i] = x[i];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each LOAD advances the phase except the first after reset or
  // on a selection change (every frame lasts >= 10 cycles > FRAME_TICKS).
  logic [1:0] m_sel;
  logic       m_phase, m_first, m_mir, fd_exp, load_next;
  int         cyc, nload;

  always @(negedge clk) begin
    row_t       e;
    logic [3:0] a;
    logic [63:0] w;
    logic [7:0] r8;
    if (!rst_n) begin
      chk("rst_addr",  rom_addr,   0);
      chk("rst_valid", row_valid,  0);
      chk("rst_idx",   row_idx,    0);
      chk("rst_data",  row_data,   0);
      chk("rst_fd",    frame_done, 0);
      sb.delete();
      m_sel = 2'd0; m_phase = 1'b0; m_first = 1'b1; m_mir = 1'b0;
      fd_exp = 1'b0; load_next = 1'b1; cyc = 0; nload = 0;
    end else begin
      cyc++;
      if (load_next) begin
        load_next = 1'b0;
        chk("load_valid", row_valid, 0);
        chk("load_fd", frame_done, fd_exp);
        if (nload == 1) chk("fd_cycle", cyc, 11);
        fd_exp = 1'b0;
        nload++;
        if (anim_sel != m_sel)  m_phase = 1'b0;
        else if (!m_first)      m_phase = (anim_sel >= 2'd2) ? 1'b0 : !m_phase;
        m_first = 1'b0;
        m_sel   = anim_sel;
`ifdef SPRITE_MIRROR_EN
        m_mir   = mirror;
`else
        m_mir   = 1'b0;
`endif
        case (anim_sel)
          2'd0:    a = m_phase ? 4'd1 : 4'd0;
          2'd1:    a = m_phase ? 4'd3 : 4'd2;
          2'd2:    a = 4'd4;
          default: a = 4'd15;
        endcase
        w = rom_word(a);
        for (int i = 0; i < 8; i++) begin
          r8 = w[63-8*i -: 8];
          if (m_mir) r8 = rev8(r8);
          e.addr = a; e.idx = 3'(i); e.data = r8;
          sb.push_back(e);
        end
      end else begin
        chk("fd_low", frame_done, 0);
        if (row_valid) begin
          if (sb.size() == 0) begin
            chk("sb_empty", row_valid, 0);
          end else begin
            e = sb[0];
            chk("row_idx",  row_idx,  e.idx);
            chk("row_data", row_data, e.data);
            chk("rom_addr", rom_addr, e.addr);
            if (nload == 1 && e.idx == 3'd0) chk("row0_cycle", cyc, 3);
            if (row_ready) begin
              void'(sb.pop_front());
              if (e.idx == 3'd7) begin
                load_next = 1'b1;
                fd_exp    = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_frames(input int n);
    int got = 0;
    int budget = n * 16 + 20;
    for (int c = 0; c < budget && got < n; c++) begin
      @(posedge clk); #1;
      if (frame_done) got++;
    end
    chk("wait_frames", got, n);
  endtask

  task automatic wait_row(input logic [3:0] a, input logic any_addr, input logic [2:0] idx);
    logic found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clk); #1;
      found = row_valid && (row_idx == idx) && (any_addr || rom_addr == a);
    end
    chk("wait_row", found, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_frames(3);

    // Backpressure on row 3 of address 0.
    wait_row(4'd0, 1'b0, 3'd3);
    row_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 row_ready = 1'b1;
    wait_frames(3);

    // Selection change while showing phase 1, then back to idle.
    wait_row(4'd1, 1'b0, 3'd2);
    anim_sel = 2'd2;
    wait_frames(3);
    wait_row(4'd4, 1'b0, 3'd4);
    anim_sel = 2'd0;
    wait_frames(3);

    anim_sel = 2'd1;
    wait_frames(5);
    anim_sel = 2'd3;
    wait_frames(2);

`ifdef SPRITE_MIRROR_EN
    anim_sel = 2'd0;
    mirror   = 1'b1;
    wait_frames(3);
    mirror   = 1'b0;
    wait_frames(2);
`endif

    // Reset in the middle of row 5.
    anim_sel = 2'd0;
    wait_frames(2);
    wait_row(4'd0, 1'b1, 3'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", row_valid, 0);
    chk("mid_rst_addr",  rom_addr,  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sprite_anim_seq.md
# sprite_anim_seq

Sequencer for the 8×8 sprite ROM (4-bit address, 64-bit combinational frame word). It selects the animation, steps frames on a programmable period and fetches the current frame word. It then streams the frame row by row to the LED-matrix/display driver over a valid/ready handshake, refreshing continuously. It sits between the pet-state logic (which picks the animation) and the display driver.

## Interface
Parameters:
- FRAME_TICKS, 25_000_000: clk cycles per animation step (0.5 s at 50 MHz); must be ≥ 2.
- CNT_W, 25: width of the tick counter; must satisfy 2^CNT_W ≥ FRAME_TICKS.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- anim_sel  in  2  animation: 0 = idle (addr 0↔1), 1 = eat (addr 2↔3), 2 = static (addr 4), 3 = test pattern (addr 15, all-ones).
- rom_addr  out  4  registered address to the sprite ROM.
- rom_data  in  64  frame word from the ROM; row r = bits [63−8r : 56−8r].
- row_data  out  8  current row, bit 7 = leftmost pixel.
- row_idx  out  3  index of row_data, 0 = top.
- row_valid  out  1  row_data/row_idx valid.
- row_ready  in  1  display driver accepts the row.
- frame_done  out  1  one-cycle pulse after row 7 is accepted.

## Operation
- FSM: LOAD → CAPTURE → SEND → LOAD, continuously.
- LOAD (1 cycle):
  - Sample anim_sel. If it differs from the value latched at the previous LOAD, clear phase to 0 and drop any pending advance.
  - Otherwise, if advance_pending is set, toggle phase for selections 0/1 and clear advance_pending. Selections 2/3 keep phase at 0.
  - Register rom_addr = {sel 0: 0+phase, 1: 2+phase, 2: 4, 3: 15}.
- CAPTURE (1 cycle): latch rom_data into the 64-bit frame register, set row_idx = 0, assert row_valid.
- SEND:
  - row_data = frame register row row_idx.
  - On row_valid & row_ready: if row_idx < 7, increment row_idx. If row_idx = 7, deassert row_valid, pulse frame_done, go to LOAD.
- Tick counter:
  - Free-running in every state, 0 … FRAME_TICKS−1, then wraps to 0.
  - Setting advance_pending on wrap saturates: several wraps before one LOAD give one advance.
  - If a wrap and a LOAD fall in the same cycle, the wrap is seen by the next LOAD.
- Frame content changes only at LOAD, so a frame never tears mid-stream.
- Reset mid-operation: all state returns to reset values immediately; any row in flight is abandoned.

## Timing
- Reset values:
  - rom_addr = 0, row_data = 0, row_idx = 0, row_valid = 0, frame_done = 0.
  - phase = 0, advance_pending = 0, tick counter = 0, latched anim_sel = 0, state = LOAD.
- Sequence after rst_n deasserts: cycle 1 LOAD, cycle 2 CAPTURE, cycle 3 row_valid = 1 with row 0.
- With row_ready held high, one row transfers per cycle. A frame takes 8 SEND cycles plus 2 overhead, 10 cycles per refresh.
- While row_valid = 1 and row_ready = 0, row_data and row_idx are held stable. row_valid never drops without a transfer, except on reset.
- frame_done is asserted during the cycle of the LOAD state that follows the last transfer.
- All outputs are registered. No combinational path from row_ready to any output.

## Configuration
- SPRITE_MIRROR_EN defined:
  - Adds input port mirror (1 bit), sampled at LOAD.
  - When mirror = 1, each row is bit-reversed before output (bit 7 ↔ bit 0) for the whole frame.
  - A change of mirror alone does not reset phase.
- Undefined: no mirror port; rows are output unmodified.

## Test plan
- Reset and first frame: anim_sel = 0, row_ready = 1, FRAME_TICKS = 4.
  - Required: rom_addr = 0.
  - Rows 0–7 = 28,54,44,38,10,14,18,10 on cycles 3–10.
  - frame_done pulses on cycle 11.
- Frame stepping: anim_sel = 1, FRAME_TICKS = 4, ready = 1.
  - Required: rom_addr alternates 2,3,2,3 on successive advancing LOADs.
  - Row 7 of addr 3 = AB.
- Backpressure: row_ready low for 5 cycles at row 3 of addr 0.
  - Required: row_data = 38 and row_idx = 3 held all 5 cycles, then row 4 = 10.
  - Ticks during the stall cause at most one phase advance.
- Selection change: switch anim_sel 0→2 mid-SEND while at phase 1.
  - Required: the current frame completes unchanged; next rom_addr = 4, rows 18,18,7E,7E,18,18,18,18.
  - Switching back to 0 restarts at addr 0.
- Reset mid-stream: rst_n low at row 5.
  - Required: row_valid = 0 and rom_addr = 0 immediately.
  - After release, rows restart at row_idx 0, row_data = 28.
- With SPRITE_MIRROR_EN, mirror = 1, anim_sel = 0: rows = 14,2A,22,1C,08,28,18,08.
